// File: rtl/m_bcd_encoder_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   state_t        : FSM state encoding (IDLE / CONV / DONE)
//   BCD_DIGIT_MAX  : largest legal BCD nibble; anything above flags err
package m_bcd_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

endpackage

// File: rtl/m_bcd_encoder_if.sv
// Handshake bundle for m_bcd_encoder.
//   in_valid/in_ready/bcd_in          : BCD operand input, valid/ready
//   out_valid/out_ready/bin_out/ovf/err : binary result output, valid/ready
// Modports: master = producer/consumer side (testbench, datapath),
//           slave  = the converter itself.
interface m_bcd_encoder_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  ovf;
    logic                  err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, ovf, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, ovf, err
    );
endinterface

// File: rtl/m_bcd_encoder_mac10.sv
// m_bcd_mac10: combinational multiply-by-ten-and-add step.
//   acc_i  [BIN_W-1:0]  running binary value
//   d_i    [3:0]        next digit nibble (10..15 used as-is)
//   step_o [BIN_W+3:0]  acc_i*10 + d_i, wide enough never to wrap
module m_bcd_mac10 #(
    parameter int BIN_W = 8
) (
    input  logic [BIN_W-1:0] acc_i,
    input  logic [3:0]       d_i,
    output logic [BIN_W+3:0] step_o
);
    logic [BIN_W+3:0] acc_ext;
    logic [BIN_W+3:0] d_ext;

    assign acc_ext = {4'b0000, acc_i};
    assign d_ext   = {{BIN_W{1'b0}}, d_i};

    // x*10 = x*8 + x*2, shift-and-add instead of a multiplier
    assign step_o = (acc_ext << 3) + (acc_ext << 1) + d_ext;
endmodule

// File: rtl/m_bcd_encoder.sv
// m_bcd_encoder: sequential BCD-to-binary converter, one digit per clock,
// most significant digit first (acc = acc*10 + d).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : m_bcd_encoder_if.slave (BCD input handshake, binary result
//          handshake with ovf/err flags)
// Configuration macro: BCD_ENC_SAT_EN -- when defined, bin_out reads
// all-ones whenever ovf is set; otherwise the wrapped value is shown.
module m_bcd_encoder
    import m_bcd_encoder_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    m_bcd_encoder_if.slave     bus
);
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t              state_q, state_d;
    logic [4*DIGITS-1:0] shift_q, shift_d;
    logic [BIN_W-1:0]    acc_q,   acc_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [BIN_W-1:0]    bin_q,   bin_d;
    logic                ovf_q,   ovf_d;
    logic                err_q,   err_d;

    logic [3:0]          digit;
    logic [BIN_W+3:0]    step;
    logic                step_ovf;

    assign digit    = shift_q[4*DIGITS-1 -: 4];
    // any bit above the result width means the true value no longer fits
    assign step_ovf = |step[BIN_W+3:BIN_W];

    m_bcd_mac10 #(.BIN_W(BIN_W)) u_mac10 (
        .acc_i  (acc_q),
        .d_i    (digit),
        .step_o (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    shift_d = bus.bcd_in;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CNT_W'(DIGITS - 1);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d = shift_q << 4;
                acc_d   = step[BIN_W-1:0];
                // flags are sticky across the digits of one conversion
                ovf_d   = ovf_q | step_ovf;
                err_d   = err_q | (digit > BCD_DIGIT_MAX);
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    bin_d   = step[BIN_W-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.ovf       = ovf_q;
        bus.err       = err_q;
`ifdef BCD_ENC_SAT_EN
        bus.bin_out   = ovf_q ? {BIN_W{1'b1}} : bin_q;
`else
        bus.bin_out   = bin_q;
`endif
    end
endmodule

// File: tb/tb_m_bcd_encoder.sv
// Randomized + directed bench for m_bcd_encoder against a plain-arithmetic
// reference model of BCD-to-binary conversion.
module tb_m_bcd_encoder;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    m_bcd_encoder_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bif ();

    m_bcd_encoder #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // True decimal value of the packed word, then range/legality tests on it.
    task automatic model(input logic [4*DIGITS-1:0] bcd, output logic [BIN_W-1:0] b,
                         output logic o, output logic e);
        int t;
        int d;
        t = 0;
        e = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = int'((bcd >> (4 * i)) & 4'hF);
            if (d > 9) e = 1'b1;
            t = t * 10 + d;
        end
        o = (t > (1 << BIN_W) - 1);
        b = BIN_W'(t % (1 << BIN_W));
`ifdef BCD_ENC_SAT_EN
        if (o) b = '1;
`endif
    endtask

    // One full transaction; bp = cycles of backpressure held in DONE.
    task automatic run(input logic [4*DIGITS-1:0] bcd, input int bp);
        logic [BIN_W-1:0] eb;
        logic eo, ee;
        int lat;
        model(bcd, eb, eo, ee);
        check("in_ready_idle", 32'(bif.in_ready), 32'd1);
        bif.in_valid = 1'b1;
        bif.bcd_in   = bcd;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        bif.bcd_in   = (4*DIGITS)'($urandom);
        lat = 0;
        while (!bif.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(DIGITS));
        check("bin_out", 32'(bif.bin_out), 32'(eb));
        check("ovf", 32'(bif.ovf), 32'(eo));
        check("err", 32'(bif.err), 32'(ee));
        for (int i = 0; i < bp; i++) begin
            bif.in_valid = i[0];
            bif.bcd_in   = (4*DIGITS)'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bif.out_valid), 32'd1);
            check("bp_in_ready", 32'(bif.in_ready), 32'd0);
            check("bp_bin_out", 32'(bif.bin_out), 32'(eb));
            check("bp_flags", {30'd0, bif.ovf, bif.err}, {30'd0, eo, ee});
        end
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b0;
        check("out_valid_taken", 32'(bif.out_valid), 32'd0);
        check("in_ready_after", 32'(bif.in_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(bif.in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(bif.out_valid), 32'd0);
        check({tag, "_bin_out"}, 32'(bif.bin_out), 32'd0);
        check({tag, "_flags"}, {30'd0, bif.ovf, bif.err}, 32'd0);
    endtask

    initial begin
        logic [4*DIGITS-1:0] bcd;
        int v;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.bcd_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run(12'h255, 0);
        run(12'h256, 1);
        run(12'h999, 0);
        run(12'h000, 2);
        run(12'h0A0, 0);
        run(12'hFFF, 0);
        run(12'h123, 5);

        // abort during CONV: reset must act without waiting for a clock edge
        bif.in_valid = 1'b1;
        bif.bcd_in   = 12'h999;
        @(posedge clk); #1;
        bif.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(12'h042, 0);

        for (int n = 0; n < 256; n++) begin
            bcd = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            run(bcd, 0);
        end

        for (int k = 0; k < 150; k++) begin
            v = int'($urandom_range(0, 3));
            run((4*DIGITS)'($urandom), v);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
